buffer_read_arbiter: RTL and testbench

- Shares the single read port of a 4-cycle-latency feature buffer between NUM_REQ aggregation engines.
- Each engine submits a burst request: base address plus length. Bursts are granted round-robin.
- For the granted burst the block issues one read address per cycle, tracks the fixed buffer latency with a tag pipeline, and routes each returned line to its owner with a per-requester valid and last flag.
- Sits between the agg engines and the buffer read port (agg_read_addr_valid / agg_read_addr / agg_read_data_valid / agg_read_data).

---
 rtl/buffer_read_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_buffer_read_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_read_arbiter.sv
// Round-robin burst arbiter for the shared read port of a fixed-latency feature buffer.
// Optional build macro ARB_LATENCY_CHECK_EN adds a sticky data-valid/tag alignment check on lat_err.
module buffer_read_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int BUFFER_ADDR_WIDTH = 11,
  parameter int BUFFER_DATA_WIDTH = 512,
  parameter int LEN_WIDTH         = 8,
  parameter int READ_LATENCY      = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*BUFFER_ADDR_WIDTH-1:0]   req_base_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]           req_len,
  output logic                                   buf_read_addr_valid,
  output logic [BUFFER_ADDR_WIDTH-1:0]           buf_read_addr,
  input  logic                                   buf_read_data_valid,
  input  logic [BUFFER_DATA_WIDTH-1:0]           buf_read_data,
  output logic [NUM_REQ-1:0]                     rsp_valid,
  output logic                                   rsp_last,
  output logic [BUFFER_DATA_WIDTH-1:0]           rsp_data,
  output logic                                   busy,
  output logic                                   lat_err,
  output logic                                   dbg_state
);

  // Handshake: a request is accepted on a rising clk edge where req_valid[i] & req_ready[i];
  // req_ready is only ever raised in IDLE and is one-hot. Responses have no backpressure.

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                          state_q, state_d;
  logic [ID_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]                 id_q, id_d;
  logic [LEN_WIDTH-1:0]            cnt_q, cnt_d;
  logic                            addr_valid_q, addr_valid_d;
  logic [BUFFER_ADDR_WIDTH-1:0]    addr_q, addr_d;

  logic [READ_LATENCY-1:0]           tag_v_q, tag_v_d;
  logic [READ_LATENCY-1:0][ID_W-1:0] tag_id_q, tag_id_d;
  logic [READ_LATENCY-1:0]           tag_last_q, tag_last_d;

  logic [NUM_REQ-1:0]              rsp_valid_q, rsp_valid_d;
  logic                            rsp_last_q, rsp_last_d;
  logic [BUFFER_DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0]              grant;
  logic                            grant_found;
  logic [ID_W-1:0]                 grant_id;
  logic [BUFFER_ADDR_WIDTH-1:0]    sel_base;
  logic [LEN_WIDTH-1:0]            sel_len;

  logic                            issue_last;
  logic                            exit_v;
  logic                            hit;

  // Round-robin search starts just after the last granted requester and wraps.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_found = 1'b0;
    grant_id    = '0;
    sel_base    = '0;
    sel_len     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = ID_W'(idx);
        sel_base    = req_base_addr[idx*BUFFER_ADDR_WIDTH +: BUFFER_ADDR_WIDTH];
        sel_len     = req_len[idx*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  assign req_ready = (state_q == IDLE) ? grant : '0;

  // cnt_q counts beats still to issue after the current one; zero marks the last beat.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    addr_valid_d = 1'b0;
    addr_d       = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d      = BURST;
          rr_ptr_d     = grant_id;
          id_d         = grant_id;
          cnt_d        = sel_len;
          addr_valid_d = 1'b1;
          addr_d       = sel_base;
        end
      end
      BURST: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d        = cnt_q - LEN_WIDTH'(1);
          addr_valid_d = 1'b1;
          addr_d       = addr_q + BUFFER_ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign issue_last = addr_valid_q && (cnt_q == '0);

  // Tag pipeline shadows the buffer latency; the last stage lines up with buf_read_data_valid.
  always_comb begin
    tag_v_d       = tag_v_q;
    tag_id_d      = tag_id_q;
    tag_last_d    = tag_last_q;
    tag_v_d[0]    = addr_valid_q;
    tag_id_d[0]   = id_q;
    tag_last_d[0] = issue_last;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_v_d[i]    = tag_v_q[i-1];
      tag_id_d[i]   = tag_id_q[i-1];
      tag_last_d[i] = tag_last_q[i-1];
    end
  end

  assign exit_v = tag_v_q[READ_LATENCY-1];
  assign hit    = exit_v && buf_read_data_valid;

  always_comb begin
    rsp_valid_d = '0;
    rsp_last_d  = 1'b0;
    rsp_data_d  = '0;
    if (hit) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tag_id_q[READ_LATENCY-1] == ID_W'(i)) begin
          rsp_valid_d[i] = 1'b1;
        end
      end
      rsp_last_d = tag_last_q[READ_LATENCY-1];
      rsp_data_d = buf_read_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      cnt_q        <= '0;
      addr_valid_q <= 1'b0;
      addr_q       <= '0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      tag_last_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_last_q   <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      addr_valid_q <= addr_valid_d;
      addr_q       <= addr_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      tag_last_q   <= tag_last_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_last_q   <= rsp_last_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

`ifdef ARB_LATENCY_CHECK_EN
  logic lat_err_q, lat_err_d;

  // Any disagreement between returned data_valid and the expected tag is sticky until reset.
  always_comb begin
    lat_err_d = lat_err_q | (exit_v != buf_read_data_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_err_q <= 1'b0;
    end else begin
      lat_err_q <= lat_err_d;
    end
  end

  assign lat_err = lat_err_q;
`else
  assign lat_err = 1'b0;
`endif

  assign buf_read_addr_valid = addr_valid_q;
  assign buf_read_addr       = addr_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_last            = rsp_last_q;
  assign rsp_data            = rsp_data_q;
  assign busy                = (state_q == BURST) | (|tag_v_q) | (|rsp_valid_q);
  assign dbg_state           = (state_q == BURST);

endmodule

// File: tb/tb_buffer_read_arbiter.sv
// Bench for buffer_read_arbiter: random and directed bursts against a cycle-stamped schedule model
// and a latency-configurable buffer stub.
module tb_buffer_read_arbiter;

  localparam int N  = 4;
  localparam int AW = 11;
  localparam int DW = 512;
  localparam int LW = 8;
  localparam int RL = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_base_addr;
  logic [N*LW-1:0]   req_len;
  logic              buf_read_addr_valid;
  logic [AW-1:0]     buf_read_addr;
  logic              buf_read_data_valid;
  logic [DW-1:0]     buf_read_data;
  logic [N-1:0]      rsp_valid;
  logic              rsp_last;
  logic [DW-1:0]     rsp_data;
  logic              busy;
  logic              lat_err;
  logic              dbg_state;

  buffer_read_arbiter #(
    .NUM_REQ(N), .BUFFER_ADDR_WIDTH(AW), .BUFFER_DATA_WIDTH(DW),
    .LEN_WIDTH(LW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base_addr(req_base_addr), .req_len(req_len),
    .buf_read_addr_valid(buf_read_addr_valid), .buf_read_addr(buf_read_addr),
    .buf_read_data_valid(buf_read_data_valid), .buf_read_data(buf_read_data),
    .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_data(rsp_data),
    .busy(busy), .lat_err(lat_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- buffer stub ----------------
  int              stub_lat = RL;
  logic [7:0]         sv;
  logic [7:0][AW-1:0] sa;

  function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = {5'(i), 16'h5A3C, a};
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv <= '0;
      sa <= '0;
    end else begin
      sv <= {sv[6:0], buf_read_addr_valid};
      sa <= {sa[6:0], buf_read_addr};
    end
  end

  assign buf_read_data_valid = sv[stub_lat-1];
  assign buf_read_data       = sv[stub_lat-1] ? line_of(sa[stub_lat-1]) : '0;

  // ---------------- requester state (driven only by the stimulus process) ----------------
  logic [N-1:0]  rv = '0;
  logic [AW-1:0] rb [N];
  logic [LW-1:0] rl [N];
  int            acc_seen [N];
  logic          lat_mode = 1'b0;
  logic          lat_probe = 1'b0;
  logic          lat_exp = 1'b0;
  logic          to_flag = 1'b0;

  assign req_valid = rv;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_base_addr[g*AW +: AW] = rb[g];
    assign req_len[g*LW +: LW]       = rl[g];
  end

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
  } iss_t;

  typedef struct {
    int            cyc;
    int            id;
    logic          last;
    logic [AW-1:0] addr;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   free_cyc = 0;
  int   last_iss = -100;
  int   rr = N - 1;
  int   acc_cnt [N];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Model view: a burst accepted in cycle c issues beat k in cycle c+1+k and returns it in
  // cycle c+1+k+RL+1; the arbiter is free again in cycle c+len+2.
  always @(negedge clk) begin : model
    logic [N-1:0]  exp_rdy;
    logic [N-1:0]  exp_v;
    logic [AW-1:0] a;
    int            gid;
    if (!rst_n) begin
      iss_q.delete();
      rsp_q.delete();
      free_cyc = cyc + 1;
      rr       = N - 1;
      last_iss = -100;
      check_eq("reset_ctl", {req_ready, buf_read_addr_valid, buf_read_addr, rsp_valid,
                             rsp_last, busy, lat_err, dbg_state}, '0);
      check_eq("reset_data", rsp_data, '0);
    end else begin
      if (iss_q.size() != 0 && iss_q[0].cyc == cyc) begin
        check_eq("issue", {dbg_state, buf_read_addr_valid, buf_read_addr}, {2'b11, iss_q[0].addr});
        last_iss = cyc;
        void'(iss_q.pop_front());
      end else begin
        check_eq("issue", {dbg_state, buf_read_addr_valid, buf_read_addr}, '0);
      end

      if (rsp_q.size() != 0 && rsp_q[0].cyc == cyc) begin
        exp_v = '0;
        exp_v[rsp_q[0].id] = 1'b1;
        check_eq("rsp_ctl", {rsp_valid, rsp_last}, {exp_v, rsp_q[0].last});
        check_eq("rsp_data", rsp_data, line_of(rsp_q[0].addr));
        void'(rsp_q.pop_front());
      end else begin
        check_eq("rsp_ctl", {rsp_valid, rsp_last}, '0);
        check_eq("rsp_data", rsp_data, '0);
      end

      if (!lat_mode) begin
        check_eq("busy", busy, last_iss >= cyc - (RL + 1));
        check_eq("lat_err", lat_err, 1'b0);
      end
      if (lat_probe) check_eq("lat_err_probe", lat_err, lat_exp);
      check_eq("timeout", to_flag, 1'b0);

      exp_rdy = '0;
      gid     = -1;
      if (cyc >= free_cyc) begin
        for (int i = 1; i <= N; i++) begin
          if (gid < 0 && rv[(rr + i) % N]) gid = (rr + i) % N;
        end
      end
      if (gid >= 0) exp_rdy[gid] = 1'b1;
      check_eq("req_ready", req_ready, exp_rdy);

      if (gid >= 0) begin
        for (int k = 0; k <= int'(rl[gid]); k++) begin
          a = rb[gid] + AW'(k);
          iss_q.push_back('{cyc: cyc + 1 + k, addr: a});
          if (!lat_mode)
            rsp_q.push_back('{cyc: cyc + RL + 2 + k, id: gid, last: (k == int'(rl[gid])), addr: a});
        end
        rr       = gid;
        free_cyc = cyc + int'(rl[gid]) + 2;
        acc_cnt[gid]++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    lat_probe = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (acc_cnt[i] != acc_seen[i]) begin
        acc_seen[i] = acc_cnt[i];
        rv[i] = 1'b0;
      end
    end
  endtask

  task automatic post(input int i, input logic [AW-1:0] base, input logic [LW-1:0] len);
    rb[i] = base;
    rl[i] = len;
    rv[i] = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((rv != '0 || iss_q.size() != 0 || rsp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) to_flag = 1'b1;
    repeat (RL + 3) tick();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    rv    = '0;
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < N; i++) begin
      rb[i] = '0;
      rl[i] = '0;
      acc_seen[i] = 0;
      acc_cnt[i] = 0;
    end
    do_reset(3);
    tick();

    post(0, 11'h010, 8'd3);               // single burst
    wait_idle(100);
    post(1, 11'h7FE, 8'd3);               // address wrap
    wait_idle(100);

    do_reset(2);                           // contention from a fresh round-robin pointer
    for (int i = 0; i < N; i++) post(i, AW'(11'h100 + 16 * i), 8'd0);
    begin
      int n;
      n = 0;
      while (rv[0] && n < 50) begin tick(); n++; end
    end
    post(0, 11'h200, 8'd0);
    wait_idle(100);

    post(1, 11'h300, 8'd1);               // back-to-back
    post(2, 11'h320, 8'd2);
    wait_idle(100);

    post(0, 11'h100, 8'd7);               // reset mid-burst
    begin
      int n;
      n = 0;
      while (rv[0] && n < 50) begin tick(); n++; end
    end
    tick();
    rst_n = 1'b0;
    rv    = '0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    post(0, 11'h040, 8'd2);
    wait_idle(100);

    post(3, 11'h7F0, 8'd255);             // longest burst, wraps the address space
    wait_idle(400);

    for (int t = 0; t < 400; t++) begin   // random traffic with occasional withdrawal
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0)
          post(i, AW'($urandom_range(0, 2047)),
               ($urandom_range(0, 15) == 0) ? LW'($urandom_range(0, 40)) : LW'($urandom_range(0, 6)));
        else if (rv[i] && $urandom_range(0, 24) == 0)
          rv[i] = 1'b0;
      end
      tick();
    end
    wait_idle(2000);

    rst_n    = 1'b0;                       // latency mismatch: stub answers one cycle early
    rv       = '0;
    stub_lat = RL - 1;
    lat_mode = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    post(0, 11'h050, 8'd0);
    repeat (12) tick();
`ifdef ARB_LATENCY_CHECK_EN
    lat_exp = 1'b1;
`else
    lat_exp = 1'b0;
`endif
    lat_probe = 1'b1;
    tick();
    repeat (5) tick();
    lat_probe = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    stub_lat = RL;
    lat_mode = 1'b0;
    tick();
    rst_n = 1'b1;
    post(2, 11'h0A0, 8'd1);
    wait_idle(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
